// File: rtl/decode_stage_if.sv
// decode_stage_if: groups the decode stage's fetch, write-back and
// decode-to-execute signals.
//   master: the pipeline around decode. It drives instr_d, pc_d, flush_e and
//           wb_*, and it receives stall_f and every *_e output.
//   slave : decode_stage itself.
`timescale 1ns/1ps
interface decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    // fetch-to-decode register and execute redirect
    logic [XLEN-1:0]       instr_d;
    logic [XLEN-1:0]       pc_d;
    logic                  flush_e;
    // write-back port
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    // hazard back to fetch
    logic                  stall_f;
    // decode-to-execute pipeline register
    logic [XLEN-1:0]       rs1_val_e;
    logic [XLEN-1:0]       rs2_val_e;
    logic [XLEN-1:0]       imm_e;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [XLEN-1:0]       pc_e;
    logic [3:0]            alu_op_e;
    logic                  alu_src_e;
    logic                  reg_we_e;
    logic                  mem_re_e;
    logic                  mem_we_e;
    logic                  branch_e;
    logic                  jump_e;
    logic [1:0]            wb_sel_e;
    logic [2:0]            funct3_e;
    logic                  illegal_e;

    modport master (
        output instr_d, pc_d, flush_e, wb_we, wb_rd, wb_data,
        input  stall_f, rs1_val_e, rs2_val_e, imm_e, rs1_e, rs2_e, rd_e, pc_e,
               alu_op_e, alu_src_e, reg_we_e, mem_re_e, mem_we_e, branch_e,
               jump_e, wb_sel_e, funct3_e, illegal_e
    );

    modport slave (
        input  instr_d, pc_d, flush_e, wb_we, wb_rd, wb_data,
        output stall_f, rs1_val_e, rs2_val_e, imm_e, rs1_e, rs2_e, rd_e, pc_e,
               alu_op_e, alu_src_e, reg_we_e, mem_re_e, mem_we_e, branch_e,
               jump_e, wb_sel_e, funct3_e, illegal_e
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage.
// This stage decodes the instruction that comes from the fetch register.
// It reads the 32-entry register file, which has a write-through bypass from
// the write-back port. It detects load-use hazards and asserts stall_f.
// It registers the decoded bundle into the decode-to-execute register.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - decode_stage_if.slave. It carries instr_d/pc_d/flush_e and wb_*
//         as inputs, and stall_f plus all *_e outputs.
// An all-zero *_e bundle is a NOP bubble.
`timescale 1ns/1ps
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int NREGS = 1 << REG_ADDR_W;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu_op;
        logic                  alu_src;
        logic                  reg_we;
        logic                  mem_re;
        logic                  mem_we;
        logic                  branch;
        logic                  jump;
        logic [1:0]            wb_sel;
        logic [2:0]            funct3;
        logic                  illegal;
    } de_t;

    // funct3 selects the ALU operation. Bit 30 selects SRA/SRAI for both
    // opcodes, and it selects SUB for OP only, because ADDI has no subtract.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic       alt,
                                                  input logic       is_op);
        case (f3)
            3'b000:  return (alt && is_op) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0]       rf_q [NREGS];
    logic [XLEN-1:0]       rf_d [NREGS];
    logic [31:0]           instr;
    logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic                  use_rs1, use_rs2;
    logic [XLEN-1:0]       rs1_val, rs2_val;
    logic                  stall;
    de_t                   dec, e_d, e_q;

    assign instr   = bus.instr_d;
    assign rs1_idx = instr[15 +: REG_ADDR_W];
    assign rs2_idx = instr[20 +: REG_ADDR_W];
    assign rd_idx  = instr[7 +: REG_ADDR_W];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Decoder. Operand values are filled in later from the register-file read ports.
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec.pc     = bus.pc_d;
        dec.funct3 = instr[14:12];
        case (instr[6:0])
            OPC_LUI: begin
                dec.alu_op = ALU_PASS_B; dec.alu_src = 1'b1; dec.reg_we = 1'b1;
                dec.imm    = imm_u;
            end
            OPC_AUIPC: begin
                dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.jump = 1'b1;
                dec.wb_sel  = WB_PC4; dec.imm = imm_j;
            end
            OPC_JALR: begin
                dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.jump = 1'b1;
                dec.wb_sel  = WB_PC4; dec.imm = imm_i; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_src = 1'b1; dec.branch = 1'b1; dec.imm = imm_b;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.mem_re = 1'b1;
                dec.wb_sel  = WB_MEM; dec.imm = imm_i; use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_src = 1'b1; dec.mem_we = 1'b1; dec.imm = imm_s;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op  = alu_from_funct(instr[14:12], instr[30], 1'b0);
                dec.alu_src = 1'b1; dec.reg_we = 1'b1; dec.imm = imm_i;
                use_rs1 = 1'b1;
            end
            OPC_OP: begin
                dec.alu_op = alu_from_funct(instr[14:12], instr[30], 1'b1);
                dec.reg_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: begin
                // An all-zero word is a bubble. Any other unknown opcode is illegal.
                // An illegal instruction keeps its PC so that a trap can report it.
                dec.funct3  = '0;
                dec.illegal = |instr;
                if (!dec.illegal) begin
                    dec.pc = '0;
                end
            end
        endcase
        if (rd_idx == '0) begin
            dec.reg_we = 1'b0;
        end
        // Unused index fields are zeroed. This means forwarding and hazard
        // logic never match on immediate bits.
        dec.rd  = dec.reg_we ? rd_idx : '0;
        dec.rs1 = use_rs1 ? rs1_idx : '0;
        dec.rs2 = use_rs2 ? rs2_idx : '0;
    end

    // Read ports return 0 for x0. When write-back targets the same register
    // in this cycle, the read returns the new data.
    assign rs1_val = (dec.rs1 == '0) ? '0 :
                     (bus.wb_we && bus.wb_rd == dec.rs1) ? bus.wb_data : rf_q[dec.rs1];
    assign rs2_val = (dec.rs2 == '0) ? '0 :
                     (bus.wb_we && bus.wb_rd == dec.rs2) ? bus.wb_data : rf_q[dec.rs2];

    // Load-use hazard. A load in execute cannot forward its result into this
    // instruction's operands, so fetch holds and a bubble goes into execute.
    assign stall = !rst && e_q.mem_re && (e_q.rd != '0) &&
                   ((e_q.rd == dec.rs1) || (e_q.rd == dec.rs2));
    assign bus.stall_f = stall;

    always_comb begin
        e_d         = dec;
        e_d.rs1_val = rs1_val;
        e_d.rs2_val = rs2_val;
        if (bus.flush_e || stall) begin
            e_d = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (bus.wb_we && bus.wb_rd != '0) begin
            rf_d[bus.wb_rd] = bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            e_q <= e_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign bus.rs1_val_e = e_q.rs1_val;
    assign bus.rs2_val_e = e_q.rs2_val;
    assign bus.imm_e     = e_q.imm;
    assign bus.pc_e      = e_q.pc;
    assign bus.rs1_e     = e_q.rs1;
    assign bus.rs2_e     = e_q.rs2;
    assign bus.rd_e      = e_q.rd;
    assign bus.alu_op_e  = e_q.alu_op;
    assign bus.alu_src_e = e_q.alu_src;
    assign bus.reg_we_e  = e_q.reg_we;
    assign bus.mem_re_e  = e_q.mem_re;
    assign bus.mem_we_e  = e_q.mem_we;
    assign bus.branch_e  = e_q.branch;
    assign bus.jump_e    = e_q.jump;
    assign bus.wb_sel_e  = e_q.wb_sel;
    assign bus.funct3_e  = e_q.funct3;
    assign bus.illegal_e = e_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// The bench applies table vectors with fixed expected values, then directed
// hazard, flush and reset sequences, then random traffic. A behavioural
// reference model of decode, the register file and the hazard rule checks
// every cycle.
`timescale 1ns/1ps
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) dif ();
    decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(dif));

    typedef struct packed {
        logic [31:0] rs1_val, rs2_val, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        alu_src, reg_we, mem_re, mem_we, branch, jump;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] v1, v2, imm;
        logic [3:0]  alu;
        logic        src, rwe, mre, mwe, br, jmp;
        logic [1:0]  wbs;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    int checks = 0;
    int passes = 0;
    logic [31:0] regs_m [32];
    exp_t        e_m = '0;
    logic        hold_m = 1'b0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'd0;
        if (we && wrd == idx) return wdata;
        return regs_m[idx];
    endfunction

    // Reference decode. The model derives immediates with signed-shift
    // arithmetic, and it looks up ALU ops in a table indexed by funct3.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic we, input logic [4:0] wrd,
                                        input logic [31:0] wdata);
        exp_t r;
        logic use1, use2;
        logic signed [31:0] si;
        logic [3:0] op_tab [8];
        logic [2:0] f3;
        r = '0; use1 = 1'b0; use2 = 1'b0; si = ins; f3 = ins[14:12];
        op_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        case (ins[6:0])
            7'h37: begin r.alu_op = 4'd10; r.alu_src = 1'b1; r.reg_we = 1'b1; r.imm = ins & 32'hFFFFF000; end
            7'h17: begin r.alu_src = 1'b1; r.reg_we = 1'b1; r.imm = ins & 32'hFFFFF000; end
            7'h6F: begin
                r.alu_src = 1'b1; r.reg_we = 1'b1; r.jump = 1'b1; r.wb_sel = 2'd2;
                r.imm = (32'(si >>> 31) << 20) | ({24'b0, ins[19:12]} << 12) |
                        ({31'b0, ins[20]} << 11) | ({22'b0, ins[30:21]} << 1);
            end
            7'h67: begin
                r.alu_src = 1'b1; r.reg_we = 1'b1; r.jump = 1'b1; r.wb_sel = 2'd2;
                r.imm = 32'(si >>> 20); use1 = 1'b1;
            end
            7'h63: begin
                r.alu_src = 1'b1; r.branch = 1'b1; use1 = 1'b1; use2 = 1'b1;
                r.imm = (32'(si >>> 31) << 12) | ({31'b0, ins[7]} << 11) |
                        ({26'b0, ins[30:25]} << 5) | ({28'b0, ins[11:8]} << 1);
            end
            7'h03: begin
                r.alu_src = 1'b1; r.reg_we = 1'b1; r.mem_re = 1'b1; r.wb_sel = 2'd1;
                r.imm = 32'(si >>> 20); use1 = 1'b1;
            end
            7'h23: begin
                r.alu_src = 1'b1; r.mem_we = 1'b1; use1 = 1'b1; use2 = 1'b1;
                r.imm = (32'(si >>> 25) << 5) | {27'b0, ins[11:7]};
            end
            7'h13: begin
                r.alu_op = (f3 == 3'd5 && ins[30]) ? 4'd7 : op_tab[f3];
                r.alu_src = 1'b1; r.reg_we = 1'b1; r.imm = 32'(si >>> 20); use1 = 1'b1;
            end
            7'h33: begin
                r.alu_op = op_tab[f3];
                if (ins[30] && f3 == 3'd5) r.alu_op = 4'd7;
                if (ins[30] && f3 == 3'd0) r.alu_op = 4'd1;
                r.reg_we = 1'b1; use1 = 1'b1; use2 = 1'b1;
            end
            default: begin
                r.illegal = (ins != 32'd0);
                r.pc = r.illegal ? pc : 32'd0;
                return r;
            end
        endcase
        r.pc = pc;
        r.funct3 = f3;
        r.reg_we = r.reg_we && (ins[11:7] != 5'd0);
        r.rd  = r.reg_we ? ins[11:7] : 5'd0;
        r.rs1 = use1 ? ins[19:15] : 5'd0;
        r.rs2 = use2 ? ins[24:20] : 5'd0;
        r.rs1_val = rd_model(r.rs1, we, wrd, wdata);
        r.rs2_val = rd_model(r.rs2, we, wrd, wdata);
        return r;
    endfunction

    function automatic exp_t dut_now();
        exp_t a;
        a.rs1_val = dif.rs1_val_e; a.rs2_val = dif.rs2_val_e; a.imm = dif.imm_e; a.pc = dif.pc_e;
        a.rs1 = dif.rs1_e; a.rs2 = dif.rs2_e; a.rd = dif.rd_e; a.alu_op = dif.alu_op_e;
        a.alu_src = dif.alu_src_e; a.reg_we = dif.reg_we_e; a.mem_re = dif.mem_re_e;
        a.mem_we = dif.mem_we_e; a.branch = dif.branch_e; a.jump = dif.jump_e;
        a.wb_sel = dif.wb_sel_e; a.funct3 = dif.funct3_e; a.illegal = dif.illegal_e;
        return a;
    endfunction

    // Each call is one clock. It drives the inputs, checks stall_f before the
    // edge, and checks the *_e bundle after the edge against the model.
    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wdata, output logic st_seen);
        exp_t dec, nxt;
        logic st_exp;
        rst = r; dif.instr_d = ins; dif.pc_d = pc; dif.flush_e = fl;
        dif.wb_we = we; dif.wb_rd = wrd; dif.wb_data = wdata;
        #1;
        dec = ref_decode(ins, pc, we, wrd, wdata);
        st_exp = !r && e_m.mem_re && (e_m.rd != 5'd0) && ((e_m.rd == dec.rs1) || (e_m.rd == dec.rs2));
        st_seen = dif.stall_f;
        check("stall_f", 192'(dif.stall_f), 192'(st_exp));
        if (r || fl || st_exp) nxt = '0;
        else nxt = dec;
        @(posedge clk); #1;
        check("e_bundle", 192'(dut_now()), 192'(nxt));
        e_m = nxt;
        if (r) begin
            for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
        end else if (we && wrd != 5'd0) begin
            regs_m[wrd] = wdata;
        end
        hold_m = st_exp && !fl && !r;
    endtask

    vec_t tbl [12];
    logic [6:0] opcs [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33, 7'h7F};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        st;
        logic [31:0] ins, pc;
        logic [113:0] act, req;
        logic [31:0] add_h;
        add_h = 32'h00318233;   // add x4,x3,x3
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;

        tbl[0]  = '{32'h00028093, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd1, 1'b0};
        tbl[1]  = '{32'h00000133, 1'b1, 5'd0, 32'h00001234, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd2, 1'b0};
        tbl[2]  = '{32'hFE000EE3, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0};
        tbl[3]  = '{32'h001000EF, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00000800, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd1, 1'b0};
        tbl[4]  = '{32'h000011B7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00001000, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd3, 1'b0};
        tbl[5]  = '{32'h40208033, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0};
        tbl[6]  = '{32'h40335293, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00000403, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd5, 1'b0};
        tbl[7]  = '{32'hFE20AC23, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0};
        tbl[8]  = '{32'h0000007F, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1};
        tbl[9]  = '{32'h00000000, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0};
        tbl[10] = '{32'h80000397, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h80000000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd7, 1'b0};
        tbl[11] = '{32'h0000A183, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 5'd3, 1'b0};

        // Reset for two cycles.
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, st);
        check("reset_bundle", 192'(dut_now()), 192'(0));

        // After reset, every register reads 0.
        for (int i = 1; i < 32; i++) begin
            ins = {7'd0, 5'(32 - i), 5'(i), 3'd0, 5'd1, 7'h33};
            step(1'b0, ins, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, st);
            check("rf_reset_read", 192'({dif.rs1_val_e, dif.rs2_val_e}), 192'(0));
        end

        // Table vectors. A bubble follows each vector.
        for (int v = 0; v < 12; v++) begin
            pc = 32'h1000 + 32'(v * 4);
            step(1'b0, tbl[v].instr, pc, 1'b0, tbl[v].we, tbl[v].wrd, tbl[v].wdata, st);
            act = {dif.rs1_val_e, dif.rs2_val_e, dif.imm_e, dif.alu_op_e, dif.alu_src_e,
                   dif.reg_we_e, dif.mem_re_e, dif.mem_we_e, dif.branch_e, dif.jump_e,
                   dif.wb_sel_e, dif.rd_e, dif.illegal_e};
            req = {tbl[v].v1, tbl[v].v2, tbl[v].imm, tbl[v].alu, tbl[v].src, tbl[v].rwe,
                   tbl[v].mre, tbl[v].mwe, tbl[v].br, tbl[v].jmp, tbl[v].wbs, tbl[v].rd, tbl[v].ill};
            check($sformatf("table_%0d", v), 192'(act), 192'(req));
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, st);
        end

        // Load-use: lw x3 then add x4,x3,x3 -> one stall, bubble, then the add.
        step(1'b0, 32'h0000A183, 32'h2000, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b0, add_h, 32'h2004, 1'b0, 1'b0, 5'd0, 32'h0, st);
        check("lu_stall", 192'(st), 192'(1));
        check("lu_bubble", 192'({dif.reg_we_e, dif.mem_re_e}), 192'(0));
        step(1'b0, add_h, 32'h2004, 1'b0, 1'b0, 5'd0, 32'h0, st);
        check("lu_release", 192'(st), 192'(0));
        check("lu_add_idx", 192'({dif.rs1_e, dif.rs2_e}), 192'({5'd3, 5'd3}));

        // lw x3 followed by lui x3: lui reads no sources, so no stall.
        step(1'b0, 32'h0000A183, 32'h2100, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b0, 32'h000011B7, 32'h2104, 1'b0, 1'b0, 5'd0, 32'h0, st);
        check("lui_no_stall", 192'(st), 192'(0));

        // Flush during a stall: stall stays asserted and a bubble enters execute.
        step(1'b0, 32'h0000A183, 32'h2200, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b0, add_h, 32'h2204, 1'b1, 1'b0, 5'd0, 32'h0, st);
        check("flush_stall", 192'(st), 192'(1));
        check("flush_stall_bubble", 192'(dut_now()), 192'(0));

        // Reset during a stall: stall drops and a bubble is loaded.
        step(1'b0, 32'h0000A183, 32'h2300, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b1, add_h, 32'h2304, 1'b0, 1'b0, 5'd0, 32'h0, st);
        check("reset_stall_drop", 192'(st), 192'(0));
        check("reset_stall_bubble", 192'(dut_now()), 192'(0));

        // Flush kills a valid sub.
        step(1'b0, 32'h40208033, 32'h2400, 1'b1, 1'b0, 5'd0, 32'h0, st);
        check("flush_sub", 192'(dut_now()), 192'(0));

        // Random traffic. The bench re-presents a stalled instruction, as fetch would.
        ins = 32'h0; pc = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic fl, rr, we;
            logic [4:0] wrd;
            int k;
            if (!hold_m) begin
                k = int'($urandom_range(0, 12));
                if (k == 12) ins = 32'h0;
                else begin
                    ins = $urandom;
                    ins[6:0]   = opcs[k];
                    ins[11:7]  = 5'($urandom_range(0, 7));
                    ins[19:15] = 5'($urandom_range(0, 7));
                    ins[24:20] = 5'($urandom_range(0, 7));
                end
                pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            end
            fl  = ($urandom_range(0, 7) == 0);
            rr  = ($urandom_range(0, 63) == 0);
            we  = 1'($urandom_range(0, 1));
            wrd = 5'($urandom_range(0, 7));
            step(rr, ins, pc, fl, we, wrd, $urandom, st);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage. Consumes the instruction word and its PC from the fetch-to-decode register.
- Decodes RV32I and owns the 32-entry register file, which is read in decode and written by the write-back port.
- Detects load-use hazards and stalls fetch.
- Registers operands, immediate and control bits into the decode-to-execute pipeline register.

Parameters:
XLEN, 32, datapath and instruction width
REG_ADDR_W, 5, register index width (2^REG_ADDR_W registers)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
instr_d  in  XLEN  instruction from fetch register (0 = bubble)
pc_d  in  XLEN  PC of instr_d
flush_e  in  1  execute redirect (taken branch/jump); kills the instruction entering execute
wb_we  in  1  register-file write enable
wb_rd  in  REG_ADDR_W  write index
wb_data  in  XLEN  write data
stall_f  out  1  combinational; holds PC and the fetch register
rs1_val_e, rs2_val_e  out  XLEN  registered operand values
imm_e  out  XLEN  registered sign-extended immediate
rs1_e, rs2_e, rd_e  out  REG_ADDR_W  registered indices (for forwarding)
pc_e  out  XLEN  registered PC
alu_op_e  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
alu_src_e  out  1  0 = rs2, 1 = imm
reg_we_e, mem_re_e, mem_we_e, branch_e, jump_e  out  1  control
wb_sel_e  out  2  0 ALU, 1 memory, 2 PC+4
funct3_e  out  3  memory width / branch condition
illegal_e  out  1  unrecognised opcode seen

Behaviour:
- Reset is synchronous, active-high, on clk.
  - Every *_e output resets to 0, which encodes a NOP bubble.
  - All registers x0..x31 clear to 0.
  - stall_f is 0 while rst=1.
- Register file:
  - Two combinational read ports and one write port.
  - A write to index 0 is ignored; x0 always reads 0.
  - Write-through bypass: if wb_we and wb_rd==rsN and wb_rd!=0 in the same cycle, the read returns wb_data.
- Decode supports LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP. imm_e is formatted per the opcode's format:
  - I: sign([31:20])
  - S: sign({[31:25],[11:7]})
  - B: sign({[31],[7],[30:25],[11:8],0})
  - U: {[31:12],12'b0}
  - J: sign({[31],[19:12],[20],[30:21],0})
  - R-type: 0.
- Control encoding by instruction class:
  - LUI: PASS_B.
  - AUIPC/branch/JAL: ADD; execute selects pc_e as operand A.
  - SRAI/SRA: selected by bit 30.
  - SUB: selected by bit 30 with OP only.
  - reg_we is forced 0 when rd==0.
- instr_d==0 is a bubble: all control 0, illegal_e=0.
- Any other unknown opcode: all control 0, illegal_e=1 for that one registered cycle.
- Load-use hazard (combinational): stall_f=1 when all of the following hold:
  - mem_re_e=1
  - rd_e!=0
  - decoded instruction reads rs1 and rd_e==rs1, or reads rs2 and rd_e==rs2.
  - U/J formats read no sources; I-format reads rs1 only.
- Pipeline register update priority each clk edge:
  1. rst: bubble.
  2. flush_e: bubble.
  3. stall_f: bubble, with decode inputs left unconsumed (fetch holds them).
  4. Otherwise: load the decoded instruction.
- Latency: an instruction present on instr_d at edge N appears on *_e after edge N.
- flush_e and stall_f together: a bubble is inserted and stall_f remains asserted as computed. Fetch's own flush discards the held instruction.
- Reset mid-stall: bubble loaded, and stall_f drops in the same cycle rst asserts.

Test Plan:
- Reset with rst=1 for 2 cycles -> all *_e=0, stall_f=0. Reads of x1..x31 return 0.
- wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, with instr_d=0x00028093 (addi x1,x5,0) in the same cycle -> next cycle rs1_val_e=0xDEADBEEF, imm_e=0, alu_op_e=ADD, alu_src_e=1, reg_we_e=1, rd_e=1.
- wb_we=1, wb_rd=0, wb_data=0x1234, then decode add x2,x0,x0 -> rs1_val_e=0, rs2_val_e=0.
- Load-use: lw x3,0(x1) (0x0000A183) followed by add x4,x3,x3 -> after the lw edge stall_f=1 for one cycle; next edge a bubble (reg_we_e=0, mem_re_e=0); following edge the add with rs1_e=rs2_e=3. A lw followed by lui x3 (0x000011B7) -> no stall.
- Immediates: beq with imm=-4 (0xFE000EE3) -> imm_e=0xFFFFFFFC, branch_e=1. jal x1,+2048 (0x001000EF) -> imm_e=0x00000800, jump_e=1, wb_sel_e=2.
- flush_e=1 with a valid sub (0x40208033) on instr_d -> *_e bubble. Opcode 0x7F -> illegal_e=1 for one cycle, then 0.
